serial_fa_adder: RTL
====================

// Module: serial_fa_adder
// PURPOSE
//   Bit-serial WIDTH-bit adder built around one mux-based full-adder cell.
//   Latches two operands and a carry-in on start, then feeds one bit pair per clock, LSB first, into the cell.
//   Registers the cell carry between bits and shifts each sum bit into a result register.
//   Sits directly upstream of the full-adder cell: it sequences the cell's a/b/cin inputs and consumes its sum/cout.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range 1..32
// PORTS
//   clk     in   1      single clock; all state updates on rising edge
//   rst     in   1      synchronous, active-high reset
//   start   in   1      request; sampled only in IDLE
//   a       in   WIDTH  operand A; sampled with start
//   b       in   WIDTH  operand B; sampled with start
//   cin     in   1      carry-in; sampled with start
//   busy    out  1      high while bits are being processed (RUN)
//   done    out  1      one-cycle completion pulse
//   sum     out  WIDTH  result; updated only at completion, then held
//   cout    out  1      final carry-out; updated only at completion, then held
// BEHAVIOUR
//   Reset: rst high at a clock edge forces the following, from any state, including mid-RUN:
//     - state=IDLE, busy=0, done=0, sum=0, cout=0
//     - the internal carry, shift register and bit counter are cleared; a partial result is discarded
//   Cell (combinational, mux form): p=a_i^b_i; s_i = cin_r ? ~p : p; c_i = p ? cin_r : a_i.
//   FSM states: IDLE, RUN, DONE.
//     IDLE: start=1 -> RUN. Latches a/b into shift registers, cin into carry reg, and clears the bit counter. start=0 -> stay.
//     RUN: on each edge:
//       - s_i shifts into the MSB of the partial register (shift right)
//       - carry reg <= c_i
//       - operand registers shift right
//       - counter increments
//       On the edge that processes bit WIDTH-1, the FSM moves to DONE, and at that same edge:
//       - sum <= completed partial register
//       - cout <= c_(WIDTH-1)
//     DONE: single cycle, then unconditionally -> IDLE.
//   Outputs:
//     - busy = (state==RUN)
//     - done = (state==DONE)
//     - busy and done are never high together
//   Latency: start high in cycle 0 -> busy high cycles 1..WIDTH -> done high in cycle WIDTH+1.
//     sum/cout are valid from cycle WIDTH+1 and held until the next completion or reset.
//   start while RUN or DONE: ignored. No queuing; the operands in flight are unaffected.
//     A new start is accepted the cycle after DONE (back-to-back throughput: one add per WIDTH+2 cycles).
//   Input changes on a/b/cin outside the start-accept cycle have no effect.
//   Arithmetic: {cout,sum} == a + b + cin, exact, modulo 2^(WIDTH+1); no overflow flag.
//   During RUN, sum/cout keep the previous result; partial bits are never visible on the outputs.
//   Counter width: $clog2(WIDTH), minimum 1 bit. WIDTH=1 gives a single RUN cycle.
// TESTING (WIDTH=8 unless noted)
//   1. a=8'h00, b=8'h00, cin=0, start pulse -> done in cycle 9 exactly; sum=8'h00, cout=0; busy high cycles 1-8.
//   2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (full carry ripple).
//      a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
//      a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0.
//   3. Start 8'h12+8'h34; pulse start again with 8'hFF+8'hFF in cycle 4 -> ignored.
//      done in cycle 9 with sum=8'h46, cout=0; the prior result is held on sum during cycles 1-8.
//   4. Start 8'hFF+8'hFF, cin=1; assert rst in cycle 5 -> next cycle IDLE, busy=0, done=0, sum=0, cout=0.
//      A fresh start then completes normally.
//   5. Back-to-back: start 8'h01+8'h01 (cin=0), then start again in the cycle after done with 8'h80+8'h80
//      -> sums 8'h02/cout 0, then 8'h00/cout 1; two done pulses 10 cycles apart.
//   6. WIDTH=1: sweep all 8 {cin,a,b} combos 000..111 -> {cout,sum} = a+b+cin for each; done 2 cycles after each start.

Source files
------------

// File: rtl/serial_fa_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in, status and result out.
interface serial_fa_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_fa_adder.sv
// Bit-serial WIDTH-bit adder: one mux-form full-adder cell fed LSB first,
// carry held in a register between bits, result published only at completion.
module serial_fa_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  serial_fa_adder_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] part_n;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_a;
  logic             bit_b;
  logic             p;
  logic             s_bit;
  logic             c_bit;
  logic             last_bit;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Full-adder cell on the current bit pair plus next-state decode
  always_comb begin
    state_n  = state;
    bit_a    = a_sr[0];
    bit_b    = b_sr[0];
    p        = bit_a ^ bit_b;
    s_bit    = carry ? ~p : p;
    c_bit    = p ? carry : bit_a;
    part_n   = WIDTH'({s_bit, part} >> 1);
    last_bit = (cnt == LAST);
    case (state)
      S_IDLE:  if (bus.start) state_n = S_RUN;
      S_RUN:   if (last_bit) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Operand shifting, carry chain and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      part  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      busy <= (state_n == S_RUN);
      done <= (state_n == S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          part  <= part_n;
          carry <= c_bit;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= part_n;
            cout <= c_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum;
  assign bus.cout = cout;

endmodule
